// File: rtl/int_to_fp_seq.sv
// Sequential 32-bit integer to float32 converter: normalises one bit per cycle,
// then rounds and packs {sign, exp, mant} behind a valid/ready handshake.
module int_to_fp_seq #(
    parameter bit ROUND_NEAREST = 1'b1,
    parameter bit SIGNED_IN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  shcnt_q, shcnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic        inexact_q, inexact_d;

    logic        accept;
    logic        sign_in;
    logic [31:0] mag_in;

    // Packs a normalised magnitude (hidden bit already at bit 31, not passed in)
    // into {inexact, float32}. A carry out of the 24-bit significand leaves the
    // stored fraction at zero and bumps the exponent by one.
    function automatic logic [32:0] round_pack(
        input logic        sign,
        input logic [30:0] frac,
        input logic [4:0]  shcnt
    );
        logic [7:0]  exp;
        logic [23:0] mant_r;
        logic        g;
        logic        s;
        logic        up;
        exp    = 8'd158 - {3'b000, shcnt};
        g      = frac[7];
        s      = |frac[6:0];
        up     = ROUND_NEAREST ? (g & (s | frac[8])) : 1'b0;
        mant_r = {1'b0, frac[30:8]} + {23'd0, up};
        if (mant_r[23]) begin
            exp = exp + 8'd1;
        end
        return {g | s, sign, exp, mant_r[22:0]};
    endfunction

    assign accept  = in_valid & (state_q == IDLE);
    assign sign_in = SIGNED_IN & in_data[31];
    assign mag_in  = sign_in ? (~in_data + 32'd1) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (mag_in == 32'd0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end
            end
            ROUND: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        sign_d     = sign_q;
        mag_d      = mag_q;
        shcnt_d    = shcnt_q;
        out_data_d = out_data_q;
        inexact_d  = inexact_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d  = sign_in;
                    mag_d   = mag_in;
                    shcnt_d = 5'd0;
                    // Zero bypasses normalisation; emit +0.0 (never -0.0).
                    if (mag_in == 32'd0) begin
                        out_data_d = 32'd0;
                        inexact_d  = 1'b0;
                    end
                end
            end
            NORM: begin
                if (!mag_q[31]) begin
                    mag_d   = {mag_q[30:0], 1'b0};
                    shcnt_d = shcnt_q + 5'd1;
                end
            end
            ROUND: begin
                {inexact_d, out_data_d} = round_pack(sign_q, mag_q[30:0], shcnt_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        sign_q  <= sign_d;
        mag_q   <= mag_d;
        shcnt_q <= shcnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= 32'd0;
            inexact_q  <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            inexact_q  <= inexact_d;
        end
    end

    assign out_data = out_data_q;
    assign inexact  = inexact_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Scoreboard bench for int_to_fp_seq: three parameterisations share one input
// stream; each result is compared against an arithmetic float32 reference.
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b1;

    logic        rdy [3];
    logic        vld [3];
    logic [31:0] dat [3];
    logic        inx [3];

    logic [32:0] sb [3][$];
    int          checks = 0;
    int          failures = 0;
    bit          si_p [3] = '{1'b1, 1'b0, 1'b1};
    bit          rn_p [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    int_to_fp_seq #(.ROUND_NEAREST(1'b1), .SIGNED_IN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]), .inexact(inx[0]));
    int_to_fp_seq #(.ROUND_NEAREST(1'b1), .SIGNED_IN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]), .inexact(inx[1]));
    int_to_fp_seq #(.ROUND_NEAREST(1'b0), .SIGNED_IN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]), .inexact(inx[2]));

    // Reference: exact value m = |x|, p = floor(log2 m); keep the top 24 bits and
    // round on the discarded remainder compared against half an ulp.
    function automatic logic [32:0] model(input logic [31:0] x, input bit si, input bit rn);
        bit              s;
        longint unsigned m, q, rem, half;
        int              p;
        bit              up;
        s = si && x[31];
        m = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        if (m == 0) return 33'd0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        rem = 0;
        up  = 1'b0;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            q    = m >> (p - 23);
            rem  = m - (q << (p - 23));
            half = 64'd1 << (p - 24);
            up   = rn && ((rem > half) || (rem == half && q[0]));
        end
        q = q + (up ? 64'd1 : 64'd0);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        return {rem != 0, s, 8'(127 + p), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until every converter is back in IDLE with its scoreboard drained.
    task automatic wait_idle(input bit rand_ready);
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2] && sb[0].size() == 0 &&
                 sb[1].size() == 0 && sb[2].size() == 0) && n < 400) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (n >= 400) fail_now("wait_idle");
    endtask

    task automatic send3(input logic [31:0] x, input logic [32:0] e0,
                         input logic [32:0] e1, input logic [32:0] e2);
        in_valid = 1'b1;
        in_data  = x;
        sb[0].push_back(e0);
        sb[1].push_back(e1);
        sb[2].push_back(e2);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send(input logic [31:0] x);
        send3(x, model(x, si_p[0], rn_p[0]), model(x, si_p[1], rn_p[1]),
              model(x, si_p[2], rn_p[2]));
    endtask

    // Called right after send(): counts edges from the accept edge to first out_valid.
    task automatic check_latency(input string name, input int want);
        int k;
        k = 1;
        while (!vld[0] && k < 100) begin
            tick();
            k++;
        end
        check(name, 33'(k), 33'(want));
    endtask

    initial begin
        logic [31:0] x;
        logic [32:0] held;
        int          seen;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int i = 0; i < 3; i++) begin
                        if (vld[i] && out_ready) begin
                            if (sb[i].size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_out dut%0d got=%h want=none", i, dat[i]);
                            end else begin
                                check($sformatf("result dut%0d", i), {inx[i], dat[i]}, sb[i].pop_front());
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state dut%0d", i), {rdy[i], vld[i], inx[i], dat[i][29:0]},
                  {1'b1, 1'b0, 1'b0, 30'd0});
            check($sformatf("reset_data dut%0d", i), {1'b0, dat[i]}, 33'd0);
        end
        rst = 1'b0;
        tick();

        send3(32'd5, {1'b0, 32'h40A00000}, model(32'd5, 1'b0, 1'b1), model(32'd5, 1'b1, 1'b0));
        check_latency("latency_5", 32);
        wait_idle(1'b0);
        send3(32'hFFFFFFFF, {1'b0, 32'hBF800000}, {1'b1, 32'h4F800000},
              model(32'hFFFFFFFF, 1'b1, 1'b0));
        wait_idle(1'b0);
        send3(32'h01000001, {1'b1, 32'h4B800000}, model(32'h01000001, 1'b0, 1'b1),
              model(32'h01000001, 1'b1, 1'b0));
        wait_idle(1'b0);
        send3(32'h01000003, {1'b1, 32'h4B800002}, model(32'h01000003, 1'b0, 1'b1),
              model(32'h01000003, 1'b1, 1'b0));
        wait_idle(1'b0);
        send3(32'h7FFFFFFF, {1'b1, 32'h4F000000}, {1'b1, 32'h4F000000}, {1'b1, 32'h4EFFFFFF});
        wait_idle(1'b0);
        send3(32'h80000000, {1'b0, 32'hCF000000}, {1'b0, 32'h4F000000}, {1'b0, 32'hCF000000});
        check_latency("latency_min", 3);
        wait_idle(1'b0);
        send3(32'd0, 33'd0, 33'd0, 33'd0);
        check_latency("latency_zero", 1);
        wait_idle(1'b0);
        send(32'd1);
        check_latency("latency_max", 34);
        wait_idle(1'b0);

        // Backpressure: result must hold while a second request is refused.
        out_ready = 1'b0;
        send(32'd12345);
        seen = 0;
        while (!(vld[0] && vld[1] && vld[2]) && seen < 100) begin
            tick();
            seen++;
        end
        if (seen >= 100) fail_now("bp_valid");
        held     = {inx[0], dat[0]};
        in_valid = 1'b1;
        in_data  = 32'h00ABCDEF;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_stable", {inx[0], dat[0]}, held);
            check("bp_ready_valid", {31'd0, rdy[0], vld[0]}, 33'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {31'd0, rdy[0], vld[0]}, 33'd2);
        check("bp_one_transfer", 33'(sb[0].size()), 33'd0);
        wait_idle(1'b0);
        send(32'd77);
        wait_idle(1'b0);

        // Reset while dut0 is normalising in_data=1.
        send(32'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_abort dut%0d", i), {31'd0, rdy[i], vld[i]}, 33'd2);
            sb[i].delete();
        end
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (vld[0] || vld[1] || vld[2]) seen++;
        end
        check("rst_no_stale", 33'(seen), 33'd0);
        send(32'h00000100);
        wait_idle(1'b0);

        // Randomised magnitudes and signs with random consumer stalls.
        for (int n = 0; n < 300; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) x = ~x + 32'd1;
            if ($urandom_range(0, 19) == 0) x = 32'd0;
            wait_idle(1'b1);
            send(x);
        end
        wait_idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
